// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit five-stage CPU: widths, opcodes,
// instruction field positions and the ID/EX pipeline bundle.
package cpu_pkg;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int IW = 16;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LW   = 4'd6;
   localparam logic [3:0] OP_SW   = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS_HI  = 8;
   localparam int RS_LO  = 6;
   localparam int RT_HI  = 5;
   localparam int RT_LO  = 3;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;
   localparam int IMM_W  = IMM_HI - IMM_LO + 1;

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic branch;
   } ctrl_t;

   typedef struct packed {
      logic          valid;
      logic [3:0]    op;
      logic [AW-1:0] rd;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc;
      ctrl_t         ctrl;
   } idex_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode: control bits, second-source selection and
// immediate sign-extension for the ID stage.
module id_decoder
   import cpu_pkg::*;
(
   input  logic [IW-1:0] instr,
   output logic [3:0]    op,
   output ctrl_t         ctrl,
   output logic          is_nop,
   output logic          rt_is_src,
   output logic [AW-1:0] rt_addr,
   output logic [DW-1:0] imm
);

   logic is_rtype;
   logic is_itype;

   assign op        = instr[OP_HI:OP_LO];
   assign is_rtype  = (op >= OP_ADD) && (op <= OP_OR);
   assign is_itype  = (op >= OP_ADDI) && (op <= OP_BEQ);
   assign is_nop    = ~(is_rtype | is_itype);
   assign rt_is_src = is_rtype | (op == OP_SW) | (op == OP_BEQ);

   // SW and BEQ carry their second source in the destination slot.
   assign rt_addr = is_rtype ? instr[RT_HI:RT_LO] : instr[RD_HI:RD_LO];
   assign imm     = {{(DW-IMM_W){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};

   always_comb begin
      ctrl          = '0;
      ctrl.regwrite = (op >= OP_ADD) && (op <= OP_LW);
      ctrl.memread  = (op == OP_LW);
      ctrl.memwrite = (op == OP_SW);
      ctrl.branch   = (op == OP_BEQ);
   end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register reads, load-use hazard detection and the
// ID/EX register. Define ID_WB_BYPASS_EN to forward a same-cycle WB write.
module id_stage #(
   parameter int DW = cpu_pkg::DW,
   parameter int AW = cpu_pkg::AW,
   parameter int IW = cpu_pkg::IW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_valid,
   input  logic [IW-1:0] if_instr,
   input  logic [DW-1:0] if_pc,
   input  logic          flush,
   input  logic          ex_ready,
   output logic [AW-1:0] rf_rs_addr,
   output logic [AW-1:0] rf_rt_addr,
   input  logic [DW-1:0] rf_rs_data,
   input  logic [DW-1:0] rf_rt_data,
`ifdef ID_WB_BYPASS_EN
   input  logic          wb_we,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
`endif
   output logic          id_stall,
   output logic          ex_valid,
   output logic [3:0]    ex_op,
   output logic [AW-1:0] ex_rd,
   output logic [AW-1:0] ex_rs,
   output logic [AW-1:0] ex_rt,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [DW-1:0] ex_imm,
   output logic [DW-1:0] ex_pc,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          ex_branch,
   output logic [7:0]    hazard_cnt
);
   import cpu_pkg::*;

   logic [3:0]    op;
   ctrl_t         ctrl;
   logic          is_nop;
   logic          rt_is_src;
   logic [AW-1:0] rs;
   logic [AW-1:0] rt;
   logic [AW-1:0] rd;
   logic [DW-1:0] imm;
   logic [DW-1:0] a_in;
   logic [DW-1:0] b_in;
   logic          hazard;
   idex_t         q;
   logic [7:0]    hcnt;

   id_decoder u_dec (
      .instr     (if_instr),
      .op        (op),
      .ctrl      (ctrl),
      .is_nop    (is_nop),
      .rt_is_src (rt_is_src),
      .rt_addr   (rt),
      .imm       (imm)
   );

   assign rs         = if_instr[RS_HI:RS_LO];
   assign rd         = if_instr[RD_HI:RD_LO];
   assign rf_rs_addr = rs;
   assign rf_rt_addr = rt;

`ifdef ID_WB_BYPASS_EN
   assign a_in = (wb_we && (wb_addr == rs)) ? wb_data : rf_rs_data;
   assign b_in = (wb_we && (wb_addr == rt)) ? wb_data : rf_rt_data;
`else
   assign a_in = rf_rs_data;
   assign b_in = rf_rt_data;
`endif

   // A load in EX whose target is read by the instruction in ID.
   assign hazard = q.valid & q.ctrl.memread & if_valid & ~is_nop &
                   ((rs == q.rd) | (rt_is_src & (rt == q.rd)));
   assign id_stall = ~rst & (hazard | ~ex_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q    <= '0;
         hcnt <= '0;
      end else if (flush) begin
         q.valid <= 1'b0;
         q.ctrl  <= '0;
      end else if (ex_ready) begin
         if (hazard) begin
            q.valid <= 1'b0;
            q.ctrl  <= '0;
            if (hcnt != 8'hFF) hcnt <= hcnt + 8'd1;
         end else begin
            q.valid <= if_valid;
            q.op    <= op;
            q.rd    <= rd;
            q.rs    <= rs;
            q.rt    <= rt;
            q.a     <= a_in;
            q.b     <= b_in;
            q.imm   <= imm;
            q.pc    <= if_pc;
            q.ctrl  <= if_valid ? ctrl : '0;
         end
      end
   end

   assign ex_valid    = q.valid;
   assign ex_op       = q.op;
   assign ex_rd       = q.rd;
   assign ex_rs       = q.rs;
   assign ex_rt       = q.rt;
   assign ex_a        = q.a;
   assign ex_b        = q.b;
   assign ex_imm      = q.imm;
   assign ex_pc       = q.pc;
   assign ex_regwrite = q.ctrl.regwrite;
   assign ex_memread  = q.ctrl.memread;
   assign ex_memwrite = q.ctrl.memwrite;
   assign ex_branch   = q.ctrl.branch;
   assign hazard_cnt  = hcnt;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expectations, a
// monitor pops and compares each cycle. Honours ID_WB_BYPASS_EN.
module tb_id_stage;

   localparam int WB_ADDR = 2;
   localparam int WB_DATA = 9;

   typedef struct {
      logic [15:0] instr;
      int pc, iv, fl, rdy, wb;
      int stall, rs, rt, crt;
      int val, op, rd, a, b, cb, imm, ci, epc, ctl, hcnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [7:0]  if_pc;
   logic        flush;
   logic        ex_ready;
   logic [2:0]  rf_rs_addr;
   logic [2:0]  rf_rt_addr;
   logic [7:0]  rf_rs_data;
   logic [7:0]  rf_rt_data;
`ifdef ID_WB_BYPASS_EN
   logic        wb_we;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_data;
`endif
   logic        id_stall;
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic [2:0]  ex_rd;
   logic [2:0]  ex_rs;
   logic [2:0]  ex_rt;
   logic [7:0]  ex_a;
   logic [7:0]  ex_b;
   logic [7:0]  ex_imm;
   logic [7:0]  ex_pc;
   logic        ex_regwrite;
   logic        ex_memread;
   logic        ex_memwrite;
   logic        ex_branch;
   logic [7:0]  hazard_cnt;

   logic [7:0]  regs [8];
   vec_t        sb [$];
   int          compared = 0;
   int          mismatched = 0;

   always #5 clk = ~clk;

   assign rf_rs_data = regs[rf_rs_addr];
   assign rf_rt_data = regs[rf_rt_addr];

   id_stage dut (
      .clk         (clk),
      .rst         (rst),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .flush       (flush),
      .ex_ready    (ex_ready),
      .rf_rs_addr  (rf_rs_addr),
      .rf_rt_addr  (rf_rt_addr),
      .rf_rs_data  (rf_rs_data),
      .rf_rt_data  (rf_rt_data),
`ifdef ID_WB_BYPASS_EN
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
`endif
      .id_stall    (id_stall),
      .ex_valid    (ex_valid),
      .ex_op       (ex_op),
      .ex_rd       (ex_rd),
      .ex_rs       (ex_rs),
      .ex_rt       (ex_rt),
      .ex_a        (ex_a),
      .ex_b        (ex_b),
      .ex_imm      (ex_imm),
      .ex_pc       (ex_pc),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .ex_memwrite (ex_memwrite),
      .ex_branch   (ex_branch),
      .hazard_cnt  (hazard_cnt)
   );

   function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
      return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
   endfunction

   function automatic logic [15:0] enc_i(input int op, input int rd, input int rs, input int imm);
      return {4'(op), 3'(rd), 3'(rs), 6'(imm)};
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      #1;
      if_instr = v.instr;
      if_pc    = 8'(v.pc);
      if_valid = 1'(v.iv);
      flush    = 1'(v.fl);
      ex_ready = 1'(v.rdy);
`ifdef ID_WB_BYPASS_EN
      wb_we   = 1'(v.wb);
      wb_addr = 3'(WB_ADDR);
      wb_data = 8'(WB_DATA);
`else
      if (v.wb != 0) regs[WB_ADDR] = 8'(WB_DATA);
`endif
      sb.push_back(v);
   endtask

   // Monitor: combinational outputs before the edge, ID/EX contents after it.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("id_stall", int'(id_stall), e.stall);
            checkOutput("rf_rs_addr", int'(rf_rs_addr), e.rs);
            if (e.crt != 0) checkOutput("rf_rt_addr", int'(rf_rt_addr), e.rt);
            @(posedge clk);
            #1;
            checkOutput("ex_valid", int'(ex_valid), e.val);
            checkOutput("ex_ctl", int'({ex_regwrite, ex_memread, ex_memwrite, ex_branch}), e.ctl);
            checkOutput("hazard_cnt", int'(hazard_cnt), e.hcnt);
            if (e.val != 0) begin
               checkOutput("ex_op", int'(ex_op), e.op);
               checkOutput("ex_rd", int'(ex_rd), e.rd);
               checkOutput("ex_a", int'(ex_a), e.a);
               checkOutput("ex_pc", int'(ex_pc), e.epc);
               if (e.cb != 0) checkOutput("ex_b", int'(ex_b), e.b);
               if (e.ci != 0) checkOutput("ex_imm", int'(ex_imm), e.imm);
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      ex_ready = 1'b0;
      if_valid = 1'b0;
      flush    = 1'b0;
      if_instr = '0;
      if_pc    = '0;
`ifdef ID_WB_BYPASS_EN
      wb_we   = 1'b0;
      wb_addr = '0;
      wb_data = '0;
`endif
      regs = '{8'd0, 8'd5, 8'd7, 8'd3, 8'd40, 8'd0, 8'd6, 8'd77};
      #3;
      checkOutput("reset ex_valid", int'(ex_valid), 0);
      checkOutput("reset hazard_cnt", int'(hazard_cnt), 0);
      checkOutput("reset id_stall", int'(id_stall), 0);
      @(negedge clk);
      rst      = 1'b0;
      ex_ready = 1'b1;

      //                 instr                 pc iv fl rdy wb  st rs rt crt val op rd  a   b  cb  imm   ci  epc  ctl     hcnt
      applyStimulus('{enc_r(1,3,1,2),        16, 1, 0, 1, 0,  0, 1, 2, 1,  1, 1, 3,  5,  7, 1,  0,    0,  16, 4'b1000, 0});
      applyStimulus('{enc_i(5,2,1,6'h3D),    17, 1, 0, 1, 0,  0, 1, 0, 0,  1, 5, 2,  5,  0, 0,  8'hFD,1,  17, 4'b1000, 0});
      applyStimulus('{enc_i(6,4,1,0),        18, 1, 0, 1, 0,  0, 1, 0, 0,  1, 6, 4,  5,  0, 0,  0,    1,  18, 4'b1100, 0});
      applyStimulus('{enc_r(1,5,4,1),        19, 1, 0, 1, 0,  1, 4, 1, 1,  0, 0, 0,  0,  0, 0,  0,    0,  0,  4'b0000, 1});
      applyStimulus('{enc_r(1,5,4,1),        19, 1, 0, 1, 0,  0, 4, 1, 1,  1, 1, 5,  40, 5, 1,  0,    0,  19, 4'b1000, 1});
      applyStimulus('{enc_i(6,4,1,0),        20, 1, 0, 1, 0,  0, 1, 0, 0,  1, 6, 4,  5,  0, 0,  0,    1,  20, 4'b1100, 1});
      applyStimulus('{enc_i(7,6,2,0),        21, 1, 0, 1, 0,  0, 2, 6, 1,  1, 7, 6,  7,  6, 1,  0,    1,  21, 4'b0010, 1});
      applyStimulus('{enc_i(6,4,1,1),        22, 1, 0, 1, 0,  0, 1, 0, 0,  1, 6, 4,  5,  0, 0,  1,    1,  22, 4'b1100, 1});
      applyStimulus('{enc_i(8,4,3,6'h3E),    23, 1, 1, 0, 0,  1, 3, 4, 1,  0, 0, 0,  0,  0, 0,  0,    0,  0,  4'b0000, 1});
      applyStimulus('{enc_r(1,1,2,3),        24, 0, 0, 1, 0,  0, 2, 3, 1,  0, 0, 0,  0,  0, 0,  0,    0,  0,  4'b0000, 1});
      applyStimulus('{enc_i(6,4,1,0),        32, 1, 0, 1, 0,  0, 1, 0, 0,  1, 6, 4,  5,  0, 0,  0,    1,  32, 4'b1100, 1});
      applyStimulus('{enc_i(8,4,3,6'h3E),    33, 1, 0, 1, 0,  1, 3, 4, 1,  0, 0, 0,  0,  0, 0,  0,    0,  0,  4'b0000, 2});
      applyStimulus('{enc_i(8,4,3,6'h3E),    33, 1, 0, 1, 0,  0, 3, 4, 1,  1, 8, 4,  3,  40,1,  8'hFE,1,  33, 4'b0001, 2});
      applyStimulus('{enc_r(1,3,1,2),        48, 1, 0, 0, 0,  1, 1, 2, 1,  1, 8, 4,  3,  40,1,  8'hFE,1,  33, 4'b0001, 2});
      applyStimulus('{enc_r(2,1,6,7),        49, 1, 0, 0, 0,  1, 6, 7, 1,  1, 8, 4,  3,  40,1,  8'hFE,1,  33, 4'b0001, 2});
      applyStimulus('{enc_r(4,2,7,0),        50, 1, 0, 0, 0,  1, 7, 0, 1,  1, 8, 4,  3,  40,1,  8'hFE,1,  33, 4'b0001, 2});
      applyStimulus('{enc_r(3,7,1,6),        51, 1, 0, 1, 0,  0, 1, 6, 1,  1, 3, 7,  5,  6, 1,  0,    0,  51, 4'b1000, 2});
      applyStimulus('{enc_i(6,7,1,0),        52, 1, 0, 1, 0,  0, 1, 0, 0,  1, 6, 7,  5,  0, 0,  0,    1,  52, 4'b1100, 2});
      applyStimulus('{16'h0FFF,              53, 1, 0, 1, 0,  0, 7, 0, 0,  1, 0, 7,  77, 0, 0,  0,    0,  53, 4'b0000, 2});
      applyStimulus('{enc_r(1,4,2,0),        54, 1, 0, 1, 1,  0, 2, 0, 1,  1, 1, 4,  9,  0, 1,  0,    0,  54, 4'b1000, 2});

      @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
      end

      // Asynchronous reset while a valid instruction sits in ID/EX.
      checkOutput("pre-reset ex_valid", int'(ex_valid), 1);
      @(negedge clk);
      #1;
      ex_ready = 1'b0;
      rst      = 1'b1;
      #1;
      checkOutput("mid-reset ex_valid", int'(ex_valid), 0);
      checkOutput("mid-reset ex_regwrite", int'(ex_regwrite), 0);
      checkOutput("mid-reset ex_op", int'(ex_op), 0);
      checkOutput("mid-reset ex_a", int'(ex_a), 0);
      checkOutput("mid-reset ex_pc", int'(ex_pc), 0);
      checkOutput("mid-reset hazard_cnt", int'(hazard_cnt), 0);
      checkOutput("mid-reset id_stall", int'(id_stall), 0);
      @(negedge clk);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
